// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared state encoding and mode constants for the race sequencer
package race_pkg;

  typedef enum logic [1:0] {
    SELECT    = 2'd0,
    COUNTDOWN = 2'd1,
    INGAME    = 2'd2,
    FINISH    = 2'd3
  } race_state_t;

  localparam int RACE_TICKS_PER_SEC  = 10;
  localparam int RACE_TIME_MIN       = 15;
  localparam int RACE_TIME_MAX       = 120;
  localparam int RACE_TIME_STEP      = 15;
  localparam int RACE_TIME_DEFAULT   = RACE_TIME_MIN;
  localparam int RACE_WORD_MIN       = 10;
  localparam int RACE_WORD_MAX       = 50;
  localparam int RACE_WORD_STEP      = 10;
  localparam int RACE_WORD_DEFAULT   = RACE_WORD_MIN;
  localparam int RACE_GAME_MAX_TICKS = 1800;

endpackage

// File: rtl/race_sequencer_if.sv
// rtl/race_sequencer_if.sv - button/datapath inputs and sequencer outputs of the race sequencer
interface race_sequencer_if;
  logic        btn_start;
  logic        btn_up;
  logic        btn_down;
  logic        mode_sw;
  logic        finish_in;
  logic [1:0]  state;
  logic        mode;
  logic [6:0]  value;
  logic [1:0]  countdown;
  logic [10:0] game_ticks;

  modport master (
    output btn_start, btn_up, btn_down, mode_sw, finish_in,
    input  state, mode, value, countdown, game_ticks
  );

  modport slave (
    input  btn_start, btn_up, btn_down, mode_sw, finish_in,
    output state, mode, value, countdown, game_ticks
  );
endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge press detector; a held level yields a single one-tick pulse
module btn_edge (
  input  logic clk_div,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/race_sequencer.sv
// rtl/race_sequencer.sv - typing race SELECT/COUNTDOWN/INGAME/FINISH sequencer on the game tick clock
// Optional pause in INGAME via down press when RACE_PAUSE_EN is defined.
module race_sequencer
  import race_pkg::*;
#(
  parameter int TICKS_PER_SEC  = RACE_TICKS_PER_SEC,
  parameter int TIME_MIN       = RACE_TIME_MIN,
  parameter int TIME_MAX       = RACE_TIME_MAX,
  parameter int TIME_STEP      = RACE_TIME_STEP,
  parameter int WORD_MIN       = RACE_WORD_MIN,
  parameter int WORD_MAX       = RACE_WORD_MAX,
  parameter int WORD_STEP      = RACE_WORD_STEP,
  parameter int GAME_MAX_TICKS = RACE_GAME_MAX_TICKS
) (
  input  logic            clk_div,
  input  logic            rst,
  race_sequencer_if.slave bus
);

  localparam int             TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [10:0]    GT_LAST   = 11'(GAME_MAX_TICKS - 1);
  localparam logic [10:0]    GT_MAX    = 11'(GAME_MAX_TICKS);

  logic start_p, up_p, down_p;

  btn_edge u_start (.clk_div(clk_div), .rst(rst), .level(bus.btn_start), .press(start_p));
  btn_edge u_up    (.clk_div(clk_div), .rst(rst), .level(bus.btn_up),    .press(up_p));
  btn_edge u_down  (.clk_div(clk_div), .rst(rst), .level(bus.btn_down),  .press(down_p));

  race_state_t   state_q;
  logic          mode_q, mode_next;
  logic [6:0]    value_q, value_next;
  logic [1:0]    cd_q, cd_next;
  logic [TW-1:0] tick_q, tick_next;
  logic [10:0]   gt_q, gt_next;
  logic          cd_done, timeout, paused;

  logic [6:0] cur_min, cur_max, cur_step, sw_min;
  assign cur_min  = mode_q     ? 7'(WORD_MIN)  : 7'(TIME_MIN);
  assign cur_max  = mode_q     ? 7'(WORD_MAX)  : 7'(TIME_MAX);
  assign cur_step = mode_q     ? 7'(WORD_STEP) : 7'(TIME_STEP);
  assign sw_min   = bus.mode_sw ? 7'(WORD_MIN) : 7'(TIME_MIN);

  // Mode change beats up/down; start beats up/down; opposing presses cancel.
  always_comb begin
    mode_next  = mode_q;
    value_next = value_q;
    if (state_q == SELECT) begin
      if (bus.mode_sw != mode_q) begin
        mode_next  = bus.mode_sw;
        value_next = sw_min;
      end else if (!start_p && up_p && !down_p) begin
        value_next = (value_q > cur_max - cur_step) ? cur_max : value_q + cur_step;
      end else if (!start_p && down_p && !up_p) begin
        value_next = (value_q < cur_min + cur_step) ? cur_min : value_q - cur_step;
      end
    end
  end

  always_comb begin
    cd_next   = cd_q;
    tick_next = tick_q;
    cd_done   = 1'b0;
    case (state_q)
      SELECT: begin
        if (start_p) begin
          cd_next   = 2'd3;
          tick_next = '0;
        end
      end
      COUNTDOWN: begin
        if (tick_q == TICK_LAST) begin
          tick_next = '0;
          cd_next   = cd_q - 2'd1;
          cd_done   = (cd_q == 2'd1);
        end else begin
          tick_next = tick_q + TW'(1);
        end
      end
      default: begin
        cd_next   = 2'd0;
        tick_next = '0;
      end
    endcase
  end

  // The increment from GAME_MAX_TICKS-1 lands exactly on the saturation value.
  always_comb begin
    gt_next = gt_q;
    timeout = (gt_q >= GT_LAST);
    case (state_q)
      SELECT, FINISH: begin
        if (start_p) gt_next = '0;
      end
      INGAME: begin
        if (start_p)      gt_next = '0;
        else if (!paused) gt_next = timeout ? GT_MAX : gt_q + 11'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= SELECT;
      mode_q  <= 1'b0;
      value_q <= 7'(TIME_MIN);
      cd_q    <= 2'd0;
      tick_q  <= '0;
      gt_q    <= '0;
    end else begin
      mode_q  <= mode_next;
      value_q <= value_next;
      cd_q    <= cd_next;
      tick_q  <= tick_next;
      gt_q    <= gt_next;
      case (state_q)
        SELECT:    if (start_p) state_q <= COUNTDOWN;
        COUNTDOWN: if (cd_done) state_q <= INGAME;
        INGAME: begin
          if (start_p)                                     state_q <= SELECT;
          else if (!paused && (bus.finish_in || timeout))  state_q <= FINISH;
        end
        FINISH:    if (start_p) state_q <= SELECT;
        default:   state_q <= SELECT;
      endcase
    end
  end

`ifdef RACE_PAUSE_EN
  // Any exit from INGAME leaves the race unpaused.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst)
      paused <= 1'b0;
    else if (state_q != INGAME || start_p || (!paused && (bus.finish_in || timeout)))
      paused <= 1'b0;
    else if (down_p)
      paused <= ~paused;
  end
`else
  assign paused = 1'b0;
`endif

  assign bus.state      = state_q;
  assign bus.mode       = mode_q;
  assign bus.value      = value_q;
  assign bus.countdown  = cd_q;
  assign bus.game_ticks = gt_q;

endmodule

// File: tb/tb_race_sequencer.sv
// tb/tb_race_sequencer.sv - scoreboard bench for race_sequencer
module tb_race_sequencer;
  import race_pkg::*;

  logic clk_div = 1'b0;
  logic rst;
  always #5 clk_div = ~clk_div;

  race_sequencer_if bus();
  race_sequencer dut (.clk_div(clk_div), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  logic [22:0] exp_q[$];
  logic [22:0] obs;
  assign obs = {bus.state, bus.mode, bus.value, bus.countdown, bus.game_ticks};

  function automatic logic [22:0] pk(input logic [1:0] st, input logic md, input int val,
                                     input int cd, input int gt);
    return {st, md, 7'(val), 2'(cd), 11'(gt)};
  endfunction

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    rst = 1'b1;
    bus.btn_start = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.mode_sw = 1'b0; bus.finish_in = 1'b0;
    repeat (3) tick();
    exp_q.push_back(pk(SELECT, 1'b0, 15, 0, 0));
    e = exp_q.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset: got %h required %h", obs, e); end
    rst = 1'b0;
    exp_q.push_back(pk(SELECT, 1'b0, 15, 0, 0));
    tick();
    e = exp_q.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_release: got %h required %h", obs, e); end
  endtask

  task automatic test_value_up();
    logic [22:0] e;
    int v;
    for (int i = 0; i < 10; i++) begin
      v = 15 + 15 * (i + 1);
      if (v > 120) v = 120;
      bus.btn_up = 1'b1;
      exp_q.push_back(pk(SELECT, 1'b0, v, 0, 0));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL value_up[%0d]: got %h required %h", i, obs, e); end
      bus.btn_up = 1'b0;
      tick();
    end
  endtask

  task automatic test_mode_switch();
    logic [22:0] e;
    // up, down, mode_sw, expected mode, expected value
    int tbl [18][5] = '{
      '{0,1,0,0,105}, '{0,0,0,0,105}, '{0,1,0,0,90},  '{0,0,0,0,90},
      '{0,0,1,1,10},  '{1,1,1,1,10},  '{0,0,1,1,10},  '{1,0,1,1,20},
      '{1,0,1,1,20},  '{1,0,1,1,20},  '{0,0,1,1,20},  '{0,1,1,1,10},
      '{0,0,1,1,10},  '{0,1,1,1,10},  '{0,0,1,1,10},  '{1,0,0,0,15},
      '{0,1,1,1,10},  '{0,0,1,1,10}
    };
    for (int i = 0; i < 18; i++) begin
      bus.btn_up   = tbl[i][0][0];
      bus.btn_down = tbl[i][1][0];
      bus.mode_sw  = tbl[i][2][0];
      exp_q.push_back(pk(SELECT, tbl[i][3][0], tbl[i][4], 0, 0));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL mode_switch[%0d]: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_countdown();
    logic [22:0] e;
    bus.btn_start = 1'b1;
    exp_q.push_back(pk(COUNTDOWN, 1'b1, 10, 3, 0));
    tick();
    e = exp_q.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL countdown_start: got %h required %h", obs, e); end
    bus.btn_start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5)  bus.mode_sw = 1'b0;
      if (k == 7)  begin bus.btn_up = 1'b1; bus.btn_down = 1'b1; end
      if (k == 8)  begin bus.btn_up = 1'b0; bus.btn_down = 1'b0; end
      if (k == 15) bus.mode_sw = 1'b1;
      if (k < 30) exp_q.push_back(pk(COUNTDOWN, 1'b1, 10, 3 - k / 10, 0));
      else        exp_q.push_back(pk(INGAME, 1'b1, 10, 0, 0));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL countdown[%0d]: got %h required %h", k, obs, e); end
    end
  endtask

  task automatic test_finish();
    logic [22:0] e;
    for (int k = 1; k <= 500; k++) begin
      exp_q.push_back(pk(INGAME, 1'b1, 10, 0, k));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL ingame[%0d]: got %h required %h", k, obs, e); end
    end
    bus.finish_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(pk(FINISH, 1'b1, 10, 0, 501));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL finish_hold[%0d]: got %h required %h", k, obs, e); end
      bus.finish_in = 1'b0;
    end
    bus.btn_start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pk(SELECT, 1'b1, 10, 0, 0));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL finish_to_select[%0d]: got %h required %h", k, obs, e); end
      bus.btn_start = 1'b0;
    end
  endtask

  task automatic test_timeout();
    logic [22:0] e;
    bus.btn_start = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      if (k < 30) exp_q.push_back(pk(COUNTDOWN, 1'b1, 10, 3 - k / 10, 0));
      else        exp_q.push_back(pk(INGAME, 1'b1, 10, 0, 0));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL timeout_cd[%0d]: got %h required %h", k, obs, e); end
      bus.btn_start = 1'b0;
    end
    for (int k = 1; k <= 1803; k++) begin
      if (k == 1800) bus.finish_in = 1'b1;
      if (k < 1800) exp_q.push_back(pk(INGAME, 1'b1, 10, 0, k));
      else          exp_q.push_back(pk(FINISH, 1'b1, 10, 0, 1800));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL timeout[%0d]: got %h required %h", k, obs, e); end
    end
    bus.finish_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [22:0] e;
    bus.btn_start = 1'b1;
    exp_q.push_back(pk(SELECT, 1'b1, 10, 0, 0));
    tick();
    bus.btn_start = 1'b0;
    bus.btn_up = 1'b1;
    exp_q.push_back(pk(SELECT, 1'b1, 20, 0, 0));
    tick();
    bus.btn_up = 1'b0;
    bus.btn_start = 1'b1;
    exp_q.push_back(pk(COUNTDOWN, 1'b1, 20, 3, 0));
    tick();
    bus.btn_start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(pk(COUNTDOWN, 1'b1, 20, 3 - k / 10, 0));
      tick();
    end
    for (int k = 0; k < 15; k++) begin
      e = exp_q.pop_front(); compared++;
      if (k == 14 && obs !== e) begin mismatched++; $display("FAIL pre_reset: got %h required %h", obs, e); end
    end
    bus.mode_sw = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    exp_q.push_back(pk(SELECT, 1'b0, 15, 0, 0));
    e = exp_q.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL async_reset: got %h required %h", obs, e); end
    exp_q.push_back(pk(SELECT, 1'b0, 15, 0, 0));
    tick();
    rst = 1'b0;
    e = exp_q.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_held: got %h required %h", obs, e); end
    bus.btn_start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      exp_q.push_back(pk(COUNTDOWN, 1'b0, 15, (k < 10) ? 3 : 2, 0));
      tick();
      e = exp_q.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL post_reset_cd[%0d]: got %h required %h", k, obs, e); end
      bus.btn_start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_value_up();
    test_mode_switch();
    test_countdown();
    test_finish();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
